peak_detector_window: RTL and testbench

Parametrised successor to the single-purpose slope-vote peak finder in the heart-rate path. It consumes a sample stream qualified by sample_valid, e.g. filtered PPG from the FIR stage. It detects peaks by windowed slope voting with deadband and refractory hold-off. Outputs are a peak strobe, a held LED, the peak amplitude, the inter-peak interval in samples, and a peak count, ready for BPM conversion and display.

---
 rtl/peak_detector_window.sv | 216 +++++++++++++++++++++
 tb/tb_peak_detector_window.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_detector_window.sv
// rtl/peak_detector_window.sv - windowed slope-vote peak detector with refractory hold-off
// Optional feature macro: PEAK_AMP_GATE_EN (adds a max-min amplitude gate on detection)
module peak_detector_window #(
   parameter int DATA_W     = 10,
   parameter int HALF_WIN   = 64,
   parameter int RISE_MIN   = 51,
   parameter int FALL_MIN   = 51,
   parameter int DEADBAND   = 0,
   parameter int REFRACT    = 20,
   parameter int HOLD       = 100,
   parameter int INTERVAL_W = 16,
   parameter int MIN_AMP    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sample_valid,
   input  logic [DATA_W-1:0]     sample,
   output logic                  peak_pulse,
   output logic                  peak_led,
   output logic [DATA_W-1:0]     peak_value,
   output logic [INTERVAL_W-1:0] interval,
   output logic                  interval_valid,
   output logic [7:0]            peak_count
);

   localparam int WIN    = 2 * HALF_WIN;
   localparam int CNT_W  = $clog2(HALF_WIN + 1);
   localparam int FILL_N = WIN + 1;
   localparam int FILL_W = $clog2(FILL_N);
   localparam int REF_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
   localparam int HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

   typedef enum logic [1:0] {
      S_FILL    = 2'd0,
      S_ARMED   = 2'd1,
      S_REFRACT = 2'd2
   } state_t;

   state_t                state_q, state_d;

   logic [DATA_W-1:0]     prev_q;
   logic                  prev_vote_q;
   logic                  first_q;
   // rise_win spans the whole window; only the newer half of falls is ever counted
   logic [WIN-1:0]        rise_win_q;
   logic [HALF_WIN-1:0]   fall_win_q;
   logic [CNT_W-1:0]      rise_cnt_q, rise_cnt_d;
   logic [CNT_W-1:0]      fall_cnt_q, fall_cnt_d;
   logic [FILL_W-1:0]     fill_cnt_q;
   logic [REF_W-1:0]      ref_cnt_q;
   logic [HOLD_W-1:0]     hold_cnt_q;
   logic [DATA_W-1:0]     max_trk_q, max_trk_d;
   logic [INTERVAL_W-1:0] ivl_cnt_q, ivl_inc;
   logic                  have_peak_q;

   logic signed [DATA_W:0] diff;
   logic                  vote, vote_fall;
   logic                  fill_done, ref_last, qualify, amp_ok;
   logic                  detect, arm_entry, ref_dec;

   // slope vote, incremental half-window counts and saturating interval increment
   always_comb begin
      diff = $signed({1'b0, sample}) - $signed({1'b0, prev_q});
      if (32'(diff) > DEADBAND)
         vote = 1'b1;
      else if (32'(diff) < -DEADBAND)
         vote = 1'b0;
      else
         vote = prev_vote_q;
      vote_fall  = ~vote;
      rise_cnt_d = rise_cnt_q + CNT_W'(rise_win_q[HALF_WIN-1]) - CNT_W'(rise_win_q[WIN-1]);
      fall_cnt_d = fall_cnt_q + CNT_W'(vote_fall) - CNT_W'(fall_win_q[HALF_WIN-1]);
      max_trk_d  = (sample > max_trk_q) ? sample : max_trk_q;
      ivl_inc    = (&ivl_cnt_q) ? ivl_cnt_q : ivl_cnt_q + INTERVAL_W'(1);
      fill_done  = (fill_cnt_q == FILL_W'(FILL_N - 1));
      ref_last   = (ref_cnt_q <= REF_W'(1));
      qualify    = (32'(rise_cnt_d) >= RISE_MIN) && (32'(fall_cnt_d) >= FALL_MIN);
   end

`ifdef PEAK_AMP_GATE_EN
   logic [DATA_W-1:0] min_trk_q, min_trk_d;

   // swing across the armed interval, including the candidate sample
   always_comb begin
      min_trk_d = (sample < min_trk_q) ? sample : min_trk_q;
      amp_ok    = (32'(max_trk_d - min_trk_d) >= MIN_AMP);
   end

   // minimum tracker, restarted whenever the detector re-arms
   always_ff @(posedge clk) begin
      if (!reset)
         min_trk_q <= '0;
      else if (sample_valid)
         min_trk_q <= arm_entry ? sample : min_trk_d;
   end
`else
   assign amp_ok = 1'b1;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset)
         state_q <= S_FILL;
      else
         state_q <= state_d;
   end

   // FSM next state, advancing only on accepted samples
   always_comb begin
      state_d = state_q;
      if (sample_valid) begin
         case (state_q)
            S_FILL:    if (fill_done) state_d = S_ARMED;
            S_ARMED:   if (qualify && amp_ok) state_d = S_REFRACT;
            S_REFRACT: if (ref_last) state_d = S_ARMED;
            default:   state_d = S_FILL;
         endcase
      end
   end

   // FSM outputs: detection, re-arm and refractory countdown strobes
   always_comb begin
      detect    = 1'b0;
      arm_entry = 1'b0;
      ref_dec   = 1'b0;
      if (sample_valid) begin
         case (state_q)
            S_FILL:    arm_entry = fill_done;
            S_ARMED:   detect    = qualify && amp_ok;
            S_REFRACT: begin
               arm_entry = ref_last;
               ref_dec   = !ref_last;
            end
            default:   ;
         endcase
      end
   end

   // previous sample, vote history window and the two half-window counts
   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_q      <= '0;
         prev_vote_q <= 1'b0;
         first_q     <= 1'b1;
         rise_win_q  <= '0;
         fall_win_q  <= '0;
         rise_cnt_q  <= '0;
         fall_cnt_q  <= '0;
      end else if (sample_valid) begin
         prev_q  <= sample;
         first_q <= 1'b0;
         if (!first_q) begin
            prev_vote_q <= vote;
            rise_win_q  <= {rise_win_q[WIN-2:0], vote};
            fall_win_q  <= {fall_win_q[HALF_WIN-2:0], vote_fall};
            rise_cnt_q  <= rise_cnt_d;
            fall_cnt_q  <= fall_cnt_d;
         end
      end
   end

   // fill counter, refractory counter and maximum tracker
   always_ff @(posedge clk) begin
      if (!reset) begin
         fill_cnt_q <= '0;
         ref_cnt_q  <= '0;
         max_trk_q  <= '0;
      end else if (sample_valid) begin
         if (state_q == S_FILL && !fill_done)
            fill_cnt_q <= fill_cnt_q + FILL_W'(1);
         if (detect)
            ref_cnt_q <= REF_W'(REFRACT);
         else if (ref_dec)
            ref_cnt_q <= ref_cnt_q - REF_W'(1);
         max_trk_q <= arm_entry ? sample : max_trk_d;
      end
   end

   // detection outputs, LED hold timer and inter-peak interval
   always_ff @(posedge clk) begin
      if (!reset) begin
         peak_pulse     <= 1'b0;
         peak_led       <= 1'b0;
         peak_value     <= '0;
         interval       <= '0;
         interval_valid <= 1'b0;
         peak_count     <= '0;
         hold_cnt_q     <= '0;
         ivl_cnt_q      <= '0;
         have_peak_q    <= 1'b0;
      end else begin
         peak_pulse     <= 1'b0;
         interval_valid <= 1'b0;
         if (sample_valid) begin
            if (detect) begin
               peak_pulse     <= 1'b1;
               peak_value     <= max_trk_d;
               peak_count     <= peak_count + 8'd1;
               interval       <= ivl_inc;
               interval_valid <= have_peak_q;
               have_peak_q    <= 1'b1;
               ivl_cnt_q      <= '0;
               hold_cnt_q     <= HOLD_W'(HOLD);
               peak_led       <= (HOLD != 0);
            end else begin
               ivl_cnt_q <= ivl_inc;
               if (hold_cnt_q != '0) begin
                  hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                  peak_led   <= (hold_cnt_q != HOLD_W'(1));
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_peak_detector_window.sv
// tb/tb_peak_detector_window.sv - randomized self-checking bench against a behavioural model
module tb_peak_detector_window;

   localparam int DATA_W     = 10;
   localparam int HALF_WIN   = 4;
   localparam int RISE_MIN   = 3;
   localparam int FALL_MIN   = 3;
   localparam int DEADBAND   = 0;
   localparam int REFRACT    = 2;
   localparam int HOLD       = 3;
   localparam int INTERVAL_W = 6;
   localparam int MIN_AMP    = 8;
`ifdef PEAK_AMP_GATE_EN
   localparam int EXP_SWING7 = 0;
`else
   localparam int EXP_SWING7 = 1;
`endif

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  sample_valid = 1'b0;
   logic [DATA_W-1:0]     sample = '0;
   logic                  peak_pulse, peak_led, interval_valid;
   logic [DATA_W-1:0]     peak_value;
   logic [INTERVAL_W-1:0] interval;
   logic [7:0]            peak_count;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // behavioural model state
   int votes[$];
   int m_first, m_prev, m_lastvote, m_acc, m_mode, m_ref, m_mx, m_mn, m_hold, m_icnt, m_have;
   int e_pulse, e_led, e_value, e_int, e_ivalid, e_count;

   int wave[16] = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 70, 60, 50, 40, 30, 20, 10};
   int lvl, dir, d_i, np;
   bit v_i;

   always #5 clk = ~clk;

   peak_detector_window #(
      .DATA_W(DATA_W), .HALF_WIN(HALF_WIN), .RISE_MIN(RISE_MIN), .FALL_MIN(FALL_MIN),
      .DEADBAND(DEADBAND), .REFRACT(REFRACT), .HOLD(HOLD), .INTERVAL_W(INTERVAL_W),
      .MIN_AMP(MIN_AMP)
   ) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
      .peak_pulse(peak_pulse), .peak_led(peak_led), .peak_value(peak_value),
      .interval(interval), .interval_valid(interval_valid), .peak_count(peak_count)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      votes.delete();
      m_first = 1; m_prev = 0; m_lastvote = 0; m_acc = 0; m_mode = 0; m_ref = 0;
      m_mx = 0; m_mn = 0; m_hold = 0; m_icnt = 0; m_have = 0;
      e_pulse = 0; e_led = 0; e_value = 0; e_int = 0; e_ivalid = 0; e_count = 0;
   endtask

   // mode: 0 = filling, 1 = armed, 2 = refractory
   task automatic m_step(input bit v, input int d);
      int diff, vote, rise, fall, inc, sat;
      bit det;
      e_pulse = 0;
      e_ivalid = 0;
      if (!v) return;
      det = 1'b0;
      if (m_first != 0) begin
         m_first = 0;
      end else begin
         diff = d - m_prev;
         if (diff > DEADBAND) vote = 1;
         else if (diff < -DEADBAND) vote = 0;
         else vote = m_lastvote;
         votes.push_front(vote);
         if (votes.size() > 2 * HALF_WIN) void'(votes.pop_back());
         m_lastvote = vote;
      end
      m_prev = d;
      m_acc++;
      if (d > m_mx) m_mx = d;
      if (d < m_mn) m_mn = d;
      case (m_mode)
         0: if (m_acc == 2 * HALF_WIN + 1) begin m_mode = 1; m_mx = d; m_mn = d; end
         1: begin
            rise = 0; fall = 0;
            for (int i = 0; i < HALF_WIN; i++) begin
               if (votes[i] == 0) fall++;
               rise += votes[i + HALF_WIN];
            end
            det = (rise >= RISE_MIN) && (fall >= FALL_MIN);
`ifdef PEAK_AMP_GATE_EN
            if (m_mx - m_mn < MIN_AMP) det = 1'b0;
`endif
            if (det) begin m_mode = 2; m_ref = REFRACT; end
         end
         default: begin
            if (m_ref <= 1) begin m_mode = 1; m_mx = d; m_mn = d; end
            else m_ref--;
         end
      endcase
      sat = (1 << INTERVAL_W) - 1;
      inc = (m_icnt + 1 > sat) ? sat : m_icnt + 1;
      if (det) begin
         e_pulse = 1; e_value = m_mx; e_count = (e_count + 1) % 256;
         e_int = inc; e_ivalid = m_have; m_have = 1; m_icnt = 0; m_hold = HOLD;
      end else begin
         m_icnt = inc;
         if (m_hold > 0) m_hold--;
      end
      e_led = (m_hold > 0) ? 1 : 0;
   endtask

   task automatic step(input bit v, input int d);
      sample_valid = v;
      sample = DATA_W'(d);
      @(posedge clk);
      #1;
      if (!reset) m_reset();
      else m_step(v, d);
   endtask

   task automatic stepc(input int d);
      step(1'b1, d);
      if (peak_pulse) np++;
   endtask

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("peak_pulse", int'(peak_pulse), e_pulse);
         chk("peak_led", int'(peak_led), e_led);
         chk("peak_value", int'(peak_value), e_value);
         chk("interval", int'(interval), e_int);
         chk("interval_valid", int'(interval_valid), e_ivalid);
         chk("peak_count", int'(peak_count), e_count);
      end
   end

   initial begin
      m_reset();
      reset = 1'b0;
      repeat (3) step(1'b1, 300);
      chk_en = 1'b1;
      chk("rst_count", int'(peak_count), 0);
      chk("rst_led", int'(peak_led), 0);
      chk("rst_value", int'(peak_value), 0);
      chk("rst_pulse", int'(peak_pulse), 0);
      reset = 1'b1;

      // single ramp peak, refractory blocking, LED hold
      for (int i = 0; i < 16; i++) begin
         step(1'b1, wave[i]);
         if (i == 11) begin
            chk("s1_pulse", int'(peak_pulse), 1);
            chk("s1_value", int'(peak_value), 80);
            chk("s1_count", int'(peak_count), 1);
            chk("s1_ivalid", int'(interval_valid), 0);
         end
         if (i == 13) begin
            chk("s4_refract_block", int'(peak_pulse), 0);
            chk("s1_led_held", int'(peak_led), 1);
         end
         if (i == 14) chk("s1_led_drop", int'(peak_led), 0);
      end

      // idle cycles do not advance anything, then a second period
      repeat (3) step(1'b0, 999);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, wave[i]);
         if (i == 11) begin
            chk("s2_pulse", int'(peak_pulse), 1);
            chk("s2_ivalid", int'(interval_valid), 1);
            chk("s2_interval", int'(interval), 16);
            chk("s2_count", int'(peak_count), 2);
         end
      end

      // reset in the middle of refractory, then restart from fill
      for (int i = 0; i < 13; i++) step(1'b1, wave[i]);
      reset = 1'b0;
      step(1'b1, 500);
      step(1'b1, 600);
      chk("s5_rst_count", int'(peak_count), 0);
      chk("s5_rst_led", int'(peak_led), 0);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, wave[i]);
         if (i == 11) begin
            chk("s5_pulse", int'(peak_pulse), 1);
            chk("s5_count", int'(peak_count), 1);
         end
      end

      // long flat stretch saturates the interval counter
      repeat (70) step(1'b1, 10);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, wave[i]);
         if (i == 11) begin
            chk("sat_interval", int'(interval), 63);
            chk("sat_ivalid", int'(interval_valid), 1);
         end
      end

      // randomized triangle-like waveform with noise, gaps and rare resets
      lvl = 500;
      dir = 1;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         v_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) dir = -dir;
         lvl += dir * int'($urandom_range(0, 12));
         if (lvl > 1000) begin lvl = 1000; dir = -1; end
         if (lvl < 20) begin lvl = 20; dir = 1; end
         d_i = lvl + int'($urandom_range(0, 4));
         step(v_i, d_i);
      end
      reset = 1'b1;

      // amplitude gate: swing of 8 versus swing of 7
      reset = 1'b0; step(1'b1, 0); reset = 1'b1;
      np = 0;
      for (int i = 0; i < 9; i++) stepc(100 - i);
      for (int i = 93; i <= 100; i++) stepc(i);
      stepc(99); stepc(98); stepc(97);
      chk("gate_swing8", np, 1);
      reset = 1'b0; step(1'b1, 0); reset = 1'b1;
      np = 0;
      for (int i = 0; i < 9; i++) stepc(100 - i);
      for (int i = 93; i <= 99; i++) stepc(i);
      stepc(98); stepc(97); stepc(96);
      chk("gate_swing7", np, EXP_SWING7);

      step(1'b0, 0);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
